// File: rtl/register_file_param.sv
// Parametrised processor register file: two combinational read ports, one
// write port, optional hardwired-zero register 0, optional same-cycle
// write-to-read bypass, and a clear engine that zeroes one entry per cycle
// after reset and on request.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal operation: reads and writes served
// SWEEP | clear engine zeroing mem[idx]; writes dropped, reads return 0
module register_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] Wd,
  input  logic              writeDataSignal,
  input  logic              clear_req,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_zero;
  logic              wr_en;

  assign busy = (state == SWEEP);

  // A write to register 0 is a no-op when it is hardwired to zero; a clear
  // request in the same cycle takes priority over the write.
  assign wr_zero = (ZERO_REG != 0) && (Rd == '0);
  assign wr_en   = writeDataSignal && !busy && !clear_req && !wr_zero;

  // Read mux: zero during sweep, hardwired zero, bypass, then stored value.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = mem[addr];
    if (busy)
      val = '0;
    else if ((ZERO_REG != 0) && (addr == '0))
      val = '0;
    else if ((BYPASS != 0) && wr_en && (Rd == addr))
      val = Wd;
    return val;
  endfunction

  // Sequencer: reset always restarts a full sweep from entry 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SWEEP;
      idx   <= '0;
    end else begin
      case (state)
        SWEEP: begin
          if (idx == IDX_LAST) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (clear_req) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
      endcase
    end
  end

  // Storage array: the sweep owns the write port while busy; no reset here,
  // contents are cleared by the sweep itself.
  always_ff @(posedge clock) begin
    if (busy)
      mem[idx] <= '0;
    else if (wr_en)
      mem[Rd] <= Wd;
  end

  // Read port 1.
  always_comb begin
    RD1 = read_port(Rs);
  end

  // Read port 2.
  always_comb begin
    RD2 = read_port(Rt);
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: reset sweep length, write/read,
// hardwired zero, bypass on and off, clear priority and async reset.
module tb_register_file_param;

  logic       clock;
  logic       reset;
  logic [4:0] Rs, Rt, Rd;
  logic [7:0] Wd;
  logic       writeDataSignal;
  logic       clear_req;
  logic [7:0] RD1, RD2, rd1_nb, rd2_nb;
  logic       busy, busy_nb;

  int n_cmp = 0;
  int n_err = 0;
  int n_busy;

  register_file_param dut (
    .clock(clock), .reset(reset), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Wd(Wd),
    .writeDataSignal(writeDataSignal), .clear_req(clear_req),
    .RD1(RD1), .RD2(RD2), .busy(busy)
  );

  register_file_param #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Wd(Wd),
    .writeDataSignal(writeDataSignal), .clear_req(clear_req),
    .RD1(rd1_nb), .RD2(rd2_nb), .busy(busy_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Counts rising edges until busy drops, bounded at 40.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      n++;
      if (!busy) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Rs = 5'd5; Rt = 5'd31; Rd = '0; Wd = '0;
    writeDataSignal = 1'b0; clear_req = 1'b0;

    // Reset held: busy high, reads zero.
    tick; tick;
    #1;
    check("rst_busy", {7'd0, busy}, 8'd1);
    check("rst_rd1", RD1, 8'h00);
    check("rst_rd2", RD2, 8'h00);

    // Release: busy for exactly 32 edges.
    reset = 1'b0;
    count_busy(n_busy);
    check("post_rst_busy_len", 8'(n_busy), 8'd32);
    check("post_rst_busy_nb", {7'd0, busy_nb}, 8'd0);
    #1;
    check("post_rst_rd1_r5", RD1, 8'h00);
    check("post_rst_rd2_r31", RD2, 8'h00);

    // Write Rd=k, Wd=2k for k=1..31.
    writeDataSignal = 1'b1;
    for (int k = 1; k < 32; k++) begin
      Rd = 5'(k);
      Wd = 8'(2 * k);
      tick;
    end
    writeDataSignal = 1'b0;
    for (int k = 1; k < 32; k++) begin
      Rs = 5'(k);
      Rt = 5'(k);
      #1;
      check("wr_rd1", RD1, 8'(2 * k));
      check("wr_rd2", RD2, 8'(2 * k));
    end

    // Hardwired zero register.
    Rd = 5'd0; Wd = 8'hAA; Rs = 5'd0; Rt = 5'd0;
    writeDataSignal = 1'b1;
    #1;
    check("zero_same_cycle", RD1, 8'h00);
    tick;
    writeDataSignal = 1'b0;
    #1;
    check("zero_after", RD1, 8'h00);
    check("zero_after_nb", rd2_nb, 8'h00);

    // Bypass: register 3 holds 6.
    Rd = 5'd3; Wd = 8'h5C; Rs = 5'd3; Rt = 5'd3;
    writeDataSignal = 1'b1;
    #1;
    check("byp_rd1", RD1, 8'h5C);
    check("byp_rd2", RD2, 8'h5C);
    check("nobyp_rd1_before", rd1_nb, 8'h06);
    check("nobyp_rd2_before", rd2_nb, 8'h06);
    tick;
    writeDataSignal = 1'b0;
    #1;
    check("byp_rd1_after", RD1, 8'h5C);
    check("nobyp_rd1_after", rd1_nb, 8'h5C);

    // Clear has priority over a same-cycle write; register 7 holds 14.
    Rs = 5'd7; Rt = 5'd7; Rd = 5'd7; Wd = 8'd99;
    writeDataSignal = 1'b1; clear_req = 1'b1;
    #1;
    check("clr_no_bypass", RD1, 8'd14);
    tick;
    clear_req = 1'b0;
    Wd = 8'h55;
    #1;
    check("clr_busy_rise", {7'd0, busy}, 8'd1);
    check("clr_rd_zero", RD1, 8'h00);
    count_busy(n_busy);
    writeDataSignal = 1'b0;
    check("clr_busy_len", 8'(n_busy), 8'd32);
    for (int k = 0; k < 32; k++) begin
      Rs = 5'(k);
      Rt = 5'(31 - k);
      #1;
      check("clr_rd1", RD1, 8'h00);
      check("clr_rd2", RD2, 8'h00);
    end

    // Async reset in IDLE: outputs respond without a clock edge.
    Rd = 5'd2; Wd = 8'h11; writeDataSignal = 1'b1;
    tick;
    writeDataSignal = 1'b0;
    Rs = 5'd2; Rt = 5'd2;
    #1;
    check("idle_rd1_r2", RD1, 8'h11);
    #1;
    reset = 1'b1;
    #1;
    check("async_idle_busy", {7'd0, busy}, 8'd1);
    check("async_idle_rd1", RD1, 8'h00);
    check("async_idle_rd2", RD2, 8'h00);
    tick;
    reset = 1'b0;
    count_busy(n_busy);
    check("async_idle_busy_len", 8'(n_busy), 8'd32);

    // Async reset at edge 10 of a clear sweep restarts the full sweep.
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    repeat (10) tick;
    #1;
    reset = 1'b1;
    #1;
    check("async_mid_busy", {7'd0, busy}, 8'd1);
    check("async_mid_rd1", RD1, 8'h00);
    check("async_mid_rd2", RD2, 8'h00);
    tick; tick;
    reset = 1'b0;
    count_busy(n_busy);
    check("async_mid_busy_len", 8'(n_busy), 8'd32);
    #1;
    check("final_rd1_r2", RD1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
